// File: rtl/circuit2_pipe.sv
// circuit2_pipe: two-stage add/compare/select/shift pipeline.
// Elastic valid/ready flow with a wrapping consumed-result counter.

module circuit2_s1_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             s1_valid,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      d        <= '0;
      e        <= '0;
      f        <= '0;
    end else if (load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        d <= a + b;
        e <= a + c;
        f <= a - b;
      end
    end
  end

endmodule

module circuit2_s2_stage #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b0,
  parameter bit SHR_ARITH  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1_valid,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic             out_ready,
  output logic             load,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] z,
  output logic             out_valid,
  output logic [15:0]      res_count
);

  logic             lt;
  logic             eq;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] x_next;
  logic [WIDTH-1:0] z_next;

  assign load = !out_valid || out_ready;

  always_comb begin
    lt = 1'b0;
    unique case (1'b1)
      SIGNED_CMP: lt = $signed(d) < $signed(e);
      default:    lt = d < e;
    endcase
    eq     = d == e;
    g      = lt ? d : e;
    h      = eq ? g : f;
    x_next = g << lt;
    z_next = h >> eq;
    // Arithmetic variant refills the vacated MSB with the sign
    if (SHR_ARITH)
      z_next = $signed(h) >>> eq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      x         <= '0;
      z         <= '0;
      res_count <= '0;
    end else begin
      if (out_valid && out_ready)
        res_count <= res_count + 16'd1;
      if (load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          x <= x_next;
          z <= z_next;
        end
      end
    end
  end

endmodule

module circuit2_pipe #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b0,
  parameter bit SHR_ARITH  = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      res_count
);

  logic             s1_valid;
  logic             s2_load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;

  // Stage 1 may refill on the same edge stage 2 drains
  assign in_ready = !s1_valid || s2_load;

  circuit2_s1_stage #(
    .WIDTH(WIDTH)
  ) u_s1 (
    .clk     (Clk),
    .rst_n   (Rst),
    .load    (in_ready),
    .in_valid(in_valid),
    .a       (a),
    .b       (b),
    .c       (c),
    .s1_valid(s1_valid),
    .d       (d),
    .e       (e),
    .f       (f)
  );

  circuit2_s2_stage #(
    .WIDTH     (WIDTH),
    .SIGNED_CMP(SIGNED_CMP),
    .SHR_ARITH (SHR_ARITH)
  ) u_s2 (
    .clk      (Clk),
    .rst_n    (Rst),
    .s1_valid (s1_valid),
    .d        (d),
    .e        (e),
    .f        (f),
    .out_ready(out_ready),
    .load     (s2_load),
    .x        (x),
    .z        (z),
    .out_valid(out_valid),
    .res_count(res_count)
  );

endmodule
